psum_read_address_generator: RTL and testbench
==============================================

Name: psum_read_address_generator

Overview:
- Read-side counterpart of the psum write address counter: drains a contiguous psum region from the psum scratchpad to the downstream output stream.
- On a start pulse it latches a base address and last offset, issues one scratchpad read per cycle, absorbs the scratchpad's fixed 1-cycle read latency, and presents the data on a valid/ready stream with a last flag.
- Sits between the psum scratchpad read port and the output/accumulation stage; the PE controller starts it once the write counter reports completion.

Parameters:
ADDR_WIDTH, 8, width of scratchpad address and offset counter
DATA_WIDTH, 16, width of one psum word

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset; 0 clears all state immediately
start  in  1  single-cycle request; accepted only when busy=0
base_addr  in  ADDR_WIDTH  first scratchpad address, sampled with accepted start
max_count  in  ADDR_WIDTH  last offset, inclusive (transfer length = max_count+1), sampled with accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse in the cycle after the last word is handshaken
rd_en  out  1  scratchpad read strobe
rd_addr  out  ADDR_WIDTH  scratchpad read address, valid while rd_en=1
rd_data  in  DATA_WIDTH  scratchpad data, valid exactly one cycle after rd_en
out_valid  out  1  output word valid
out_data  out  DATA_WIDTH  output word
out_last  out  1  high with the word at offset max_count
out_ready  in  1  downstream accept; transfer when out_valid & out_ready

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0; FSM=IDLE; read/issue counters=0; skid FIFO empty.
- FSM states:
  - IDLE: start=1 latches base_addr and max_count, clears counters, goes to READ.
  - READ: issues reads. After issuing the read at offset max_count, goes to DRAIN.
  - DRAIN: waits for the final output handshake, pulses done, goes to IDLE.
- Read issue: rd_en=1 in READ when (fifo_count + inflight) < 2, where inflight = rd_en of the previous cycle. rd_addr = base + issue_offset, modulo 2^ADDR_WIDTH; wrap past all-ones is legal and wraps to 0.
- Capture: rd_data is written into a 2-entry skid FIFO the cycle after rd_en. The FIFO head drives out_data/out_valid. out_last = head tag (offset == max_count). A simultaneous push and pop keeps the count unchanged.
- Latency: start sampled at edge T → rd_en high in cycle T+1 → out_valid high in cycle T+2.
- Throughput: with out_ready held high, one word per cycle, no bubbles.
- Backpressure: while out_ready=0, at most 2 words are outstanding (FIFO + inflight); no data is lost or duplicated. out_data/out_valid/out_last stay stable while out_valid=1 and out_ready=0.
- Arithmetic: offsets are ADDR_WIDTH bits. max_count = 2^ADDR_WIDTH-1 gives a full-depth transfer; the offset counter must not wrap before last is detected.
- max_count=0 transfers exactly one word, with out_last=1 on that word.
- start while busy=1 is ignored; latched parameters do not change.
- done goes high in the cycle after the handshake of the out_last word. busy falls in that same cycle, so start is acceptable in the same cycle done=1.
- rst asserted mid-transfer immediately forces all outputs to their reset values and discards FIFO contents. No done pulse is generated.

Decomposition:
- Shared package psum_pkg: FSM state encoding (IDLE, READ, DRAIN), constant for the scratchpad read latency (1), and constant for the skid depth (2).
- One natural sub-module: psum_skid_fifo (2-entry, DATA_WIDTH+1 bits wide to carry the last tag, push/pop/full/empty, same clk/rst).

Test Plan:
- Basic transfer: base=0x10, max_count=3, out_ready=1 → rd_addr 0x10..0x13 on consecutive cycles; out_data equals scratchpad contents in order; out_last on the 4th word; done one cycle later; first out_valid 2 cycles after start.
- Single word: max_count=0, base=0x00 → exactly one rd_en and one word with out_last=1; done pulses once.
- Wrap-around: base=0xFE, max_count=3 → rd_addr sequence 0xFE, 0xFF, 0x00, 0x01; 4 words delivered.
- Backpressure: max_count=7; drop out_ready for 5 cycles mid-stream and toggle it every other cycle → all 8 words delivered in order; output stable while stalled; never more than 2 words outstanding.
- Start while busy: pulse start again during a transfer with base=0x80 → ignored, and the original sequence completes. A start in the cycle done=1 launches a new transfer.
- Reset mid-operation: drive rst=0 at the 3rd word → all outputs 0 asynchronously; after release, busy=0 and no done; a new start works normally.

Source files
------------

// File: rtl/psum_read_address_generator_pkg.sv
// Shared definitions for the psum read-side drain path: FSM encoding and
// scratchpad/skid sizing constants.
package psum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int RD_LATENCY = 1;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/psum_read_address_generator_if.sv
// Scratchpad read port plus output stream, bundled so the generator sees one bus.
interface psum_read_address_generator_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output rd_en, rd_addr, out_valid, out_data, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/psum_read_address_generator_skid_fifo.sv
// Small circular FIFO that parks scratchpad words while the output stream stalls.
module psum_skid_fifo
  import psum_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(SKID_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; the head is only observed while empty_o is low.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/psum_read_address_generator.sv
// Drains a contiguous psum region from the scratchpad onto a valid/ready stream,
// absorbing the 1-cycle read latency with a bypassed 2-entry skid FIFO.
module psum_read_address_generator
  import psum_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] max_count,
  output logic                  busy,
  output logic                  done,
  psum_read_address_generator_if.master bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] max_q, max_d;
  logic [ADDR_WIDTH-1:0] issue_q, issue_d;
  logic                  done_q, done_d;
  logic                  inflight_q, inflight_last_q;

  logic                  rd_en, is_last_issue, handshake;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]   fifo_wdata, fifo_rdata, out_word;

  assign is_last_issue = (issue_q == max_q);

  // Issue only while FIFO + inflight holds fewer than two words.
  assign rd_en = (state_q == ST_READ) && !fifo_full && !(!fifo_empty && inflight_q);

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_en ? (base_q + issue_q) : '0;

  // Words returning from the scratchpad bypass the FIFO when it is empty and
  // the stream accepts them; otherwise they are parked behind the head.
  assign fifo_wdata = {inflight_last_q, bus.rd_data};
  assign fifo_pop   = !fifo_empty && bus.out_ready;
  assign fifo_push  = inflight_q && (!fifo_empty || !bus.out_ready);

  always_comb begin
    out_word = '0;
    if (!fifo_empty)     out_word = fifo_rdata;
    else if (inflight_q) out_word = fifo_wdata;
  end

  assign bus.out_valid = !fifo_empty || inflight_q;
  assign bus.out_data  = out_word[DATA_WIDTH-1:0];
  assign bus.out_last  = out_word[DATA_WIDTH];
  assign handshake     = bus.out_valid && bus.out_ready;

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    max_d   = max_q;
    issue_d = issue_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          max_d   = max_count;
          issue_d = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_en) begin
          issue_d = issue_q + ADDR_WIDTH'(1);
          if (is_last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (handshake && bus.out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      max_q           <= '0;
      issue_q         <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      max_q           <= max_d;
      issue_q         <= issue_d;
      done_q          <= done_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && is_last_issue;
    end
  end

  psum_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .wdata_i(fifo_wdata),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_psum_read_address_generator.sv
// Directed bench: scratchpad model, transfer-level expected-word queue and a
// per-cycle monitor, plus literal pins on addresses, data and timing.
module tb_psum_read_address_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] max_count;
  logic       busy;
  logic       done;

  psum_read_address_generator_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  psum_read_address_generator #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .max_count(max_count),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scratchpad model: word at address a is {a ^ 8'hA5, a}, returned one cycle after rd_en.
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'hA5, 8'(i)};

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    else           bus.rd_data <= 16'hDEAD;
  end

  // Transfer-level model, sampled on the falling edge.
  logic [16:0] exp_q [$];
  logic [7:0]  addr_log [$];
  logic [15:0] got_log [$];
  logic        last_log [$];
  int          xbase, xmax, n_iss, n_acc, cyc, start_cyc;
  bit          exp_done, model_busy, prev_stall, first_rd, first_ov;
  logic [16:0] held_word;
  logic [7:0]  a;
  logic [16:0] e;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      n_iss = 0; n_acc = 0;
      exp_done = 0; model_busy = 0; prev_stall = 0;
      first_rd = 0; first_ov = 0;
    end else begin
      check("done", done, exp_done);
      check("busy", busy, model_busy);
      exp_done = 0;
      check("outstanding_le_2", (n_iss - n_acc) <= 2, 1'b1);
      if (bus.rd_en) begin
        a = 8'(xbase + n_iss);
        check("rd_addr", bus.rd_addr, a);
        check("rd_in_range", n_iss <= xmax, 1'b1);
        if (first_rd) check("rd_latency", cyc - start_cyc, 1);
        first_rd = 0;
        addr_log.push_back(bus.rd_addr);
        n_iss++;
      end
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_word", {bus.out_last, bus.out_data}, held_word);
      end
      if (bus.out_valid) begin
        if (first_ov) check("valid_latency", cyc - start_cyc, 2);
        first_ov = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e[15:0]);
          check("out_last", bus.out_last, e[16]);
          if (e[16]) begin
            exp_done = 1;
            model_busy = 0;
          end
        end
        got_log.push_back(bus.out_data);
        last_log.push_back(bus.out_last);
        n_acc++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held_word  = {bus.out_last, bus.out_data};
      if (start && !busy) begin
        xbase = int'(base_addr);
        xmax  = int'(max_count);
        for (int i = 0; i <= xmax; i++) begin
          a = 8'(xbase + i);
          exp_q.push_back({i == xmax, mem[a]});
        end
        n_iss = 0; n_acc = 0;
        start_cyc = cyc;
        first_rd = 1; first_ov = 1;
        model_busy = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    got_log.delete();
    last_log.delete();
  endtask

  task automatic start_xfer(input logic [7:0] b, input logic [7:0] m);
    start = 1'b1; base_addr = b; max_count = m;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    tick();
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_en"}, bus.rd_en, 1'b0);
    check({tag, "_rd_addr"}, bus.rd_addr, 8'h00);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, bus.out_data, 16'h0000);
    check({tag, "_out_last"}, bus.out_last, 1'b0);
  endtask

  logic [7:0] wrap_addr [4];

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; max_count = '0;
    bus.out_ready = 1'b1;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // Basic transfer: base 0x10, four words, ready high.
    clear_logs();
    start_xfer(8'h10, 8'd3);
    wait_done(40);
    check("basic_nreads", addr_log.size(), 4);
    check("basic_nwords", got_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("basic_addr", addr_log[i], 8'h10 + 8'(i));
    if (got_log.size() == 4) begin
      check("basic_word0", got_log[0], 16'hB510);
      check("basic_word3", got_log[3], 16'hB613);
      check("basic_last0", last_log[0], 1'b0);
      check("basic_last3", last_log[3], 1'b1);
    end

    // Single word.
    tick();
    clear_logs();
    start_xfer(8'h00, 8'd0);
    wait_done(40);
    check("single_nreads", addr_log.size(), 1);
    check("single_nwords", got_log.size(), 1);
    if (got_log.size() == 1) begin
      check("single_word", got_log[0], 16'hA500);
      check("single_last", last_log[0], 1'b1);
    end

    // Address wrap past 0xFF.
    tick();
    clear_logs();
    start_xfer(8'hFE, 8'd3);
    wait_done(40);
    wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check("wrap_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("wrap_addr", addr_log[i], wrap_addr[i]);
    if (got_log.size() == 4) check("wrap_word2", got_log[2], 16'hA500);

    // Backpressure: five-cycle stall mid-stream, then ready toggling.
    tick();
    clear_logs();
    start_xfer(8'h40, 8'd7);
    for (int c = 0; c < 80; c++) begin
      if (c < 2)      bus.out_ready = 1'b1;
      else if (c < 7) bus.out_ready = 1'b0;
      else            bus.out_ready = c[0];
      tick();
      if (done) break;
    end
    check("bp_done", done, 1'b1);
    check("bp_nwords", got_log.size(), 8);
    if (got_log.size() == 8) check("bp_word7", got_log[7], 16'hE247);
    bus.out_ready = 1'b1;

    // Start while busy is ignored; start in the done cycle is accepted.
    tick();
    clear_logs();
    start_xfer(8'h20, 8'd5);
    tick();
    start_xfer(8'h80, 8'd2);
    wait_done(40);
    start_xfer(8'h90, 8'd1);
    wait_done(40);
    check("busy_nwords", got_log.size(), 8);
    if (addr_log.size() == 8) begin
      check("busy_addr5", addr_log[5], 8'h25);
      check("busy_addr6", addr_log[6], 8'h90);
    end

    // Reset asserted while the third word is on the stream.
    tick();
    clear_logs();
    start_xfer(8'h30, 8'd7);
    for (int n = 0; n < 40 && got_log.size() < 2; n++) tick();
    check("rst_two_words", got_log.size(), 2);
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done, 1'b0);
    clear_logs();
    start_xfer(8'h10, 8'd3);
    wait_done(40);
    check("post_rst_nwords", got_log.size(), 4);
    if (got_log.size() == 4) check("post_rst_word0", got_log[0], 16'hB510);

    // Full-depth transfer: offset counter must not wrap before the last word.
    tick();
    clear_logs();
    start_xfer(8'h00, 8'hFF);
    wait_done(300);
    check("full_nwords", got_log.size(), 256);
    if (addr_log.size() == 256) check("full_addr255", addr_log[255], 8'hFF);
    if (last_log.size() == 256) begin
      check("full_last254", last_log[254], 1'b0);
      check("full_last255", last_log[255], 1'b1);
    end

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
